// File: rtl/apb_uart_regs.sv
// apb_uart_regs: APB3 register slave in front of the UART FIFOs.
// APB writes to TXDATA push the TX FIFO, APB reads of RXDATA pop the RX FIFO.
// Sticky error flags and a saturating receive-error counter are kept here.
// Every transfer is setup + one wait cycle (ACCESS) + completion (DONE).
// Optional build macro: APB_UART_IRQ_EN adds the CTRL register contents and
// the registered irq output; without it CTRL reads 0 and ignores writes.
//
// state  | meaning
// IDLE   | no transfer in flight; waits for an APB setup phase
// ACCESS | first enable cycle, pready=0; side effects and read data captured
// DONE   | pready=1 with registered prdata/pslverr

module apb_uart_regs #(
    parameter int DATA_BITS  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  tx_fifo_wr_en,
    output logic [DATA_BITS-1:0]  tx_fifo_din,
    input  logic                  tx_fifo_full,
    output logic                  rx_fifo_rd_en,
    input  logic [DATA_BITS-1:0]  rx_fifo_dout,
    input  logic                  rx_fifo_empty,
    input  logic                  rx_error
`ifdef APB_UART_IRQ_EN
    ,
    output logic                  irq
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pslverr_q, pslverr_d;
    logic        rx_error_q;
    logic        rx_err_sticky_q, rx_err_sticky_d;
    logic        tx_ovr_q, tx_ovr_d;
    logic        rx_udr_q, rx_udr_d;
    logic [7:0]  rx_err_cnt_q, rx_err_cnt_d;

    logic        in_access;
    logic        aligned;
    logic        sel_tx, sel_rx, sel_stat, sel_ctrl;
    logic        tx_ovr_set, rx_udr_set, stat_w1c;
    logic        clr_err, clr_ovr, clr_udr;
    logic        rx_err_rise;
    logic [31:0] status_word;
    logic [31:0] ctrl_rdata;

    assign in_access = (state_q == ST_ACCESS);
    assign aligned   = (paddr[1:0] == 2'b00);
    assign sel_tx    = aligned && (paddr[3:2] == 2'd0);
    assign sel_rx    = aligned && (paddr[3:2] == 2'd1);
    assign sel_stat  = aligned && (paddr[3:2] == 2'd2);
    assign sel_ctrl  = aligned && (paddr[3:2] == 2'd3);

    // FIFO strobes come straight from the ACCESS state, so they can never
    // outlast that single cycle and vanish the moment reset pulls the FSM away.
    assign tx_fifo_wr_en = in_access & pwrite & sel_tx & ~tx_fifo_full;
    assign tx_fifo_din   = tx_fifo_wr_en ? pwdata[DATA_BITS-1:0] : '0;
    assign rx_fifo_rd_en = in_access & ~pwrite & sel_rx & ~rx_fifo_empty;

    assign tx_ovr_set = in_access & pwrite & sel_tx & tx_fifo_full;
    assign rx_udr_set = in_access & ~pwrite & sel_rx & rx_fifo_empty;
    assign stat_w1c   = in_access & pwrite & sel_stat;
    assign clr_err    = stat_w1c & pwdata[2];
    assign clr_ovr    = stat_w1c & pwdata[3];
    assign clr_udr    = stat_w1c & pwdata[4];

    assign rx_err_rise = rx_error & ~rx_error_q;

    assign status_word = {16'h0000, rx_err_cnt_q, 3'b000, rx_udr_q, tx_ovr_q,
                          rx_err_sticky_q, ~rx_fifo_empty, tx_fifo_full};

    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;
    assign pready  = (state_q == ST_DONE);

    // FSM next state; ACCESS lines up with the first enable cycle so a
    // transfer costs setup + one wait state + done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (psel && !penable) state_d = ST_ACCESS;
            ST_ACCESS: state_d = psel ? ST_DONE : ST_IDLE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Read data and error response, captured only during ACCESS.
    always_comb begin
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        if (in_access) begin
            prdata_d  = '0;
            pslverr_d = 1'b0;
            if (!aligned) begin
                pslverr_d = 1'b1;
            end else if (sel_tx) begin
                pslverr_d = pwrite & tx_fifo_full;
            end else if (sel_rx) begin
                if (pwrite || rx_fifo_empty) pslverr_d = 1'b1;
                else                         prdata_d  = 32'(rx_fifo_dout);
            end else if (sel_stat) begin
                if (!pwrite) prdata_d = status_word;
            end else if (sel_ctrl) begin
                if (!pwrite) prdata_d = ctrl_rdata;
            end
        end
    end

    // Sticky flags and error counter; a same-cycle set beats a W1C clear.
    always_comb begin
        rx_err_sticky_d = rx_err_rise | (rx_err_sticky_q & ~clr_err);
        tx_ovr_d        = tx_ovr_set  | (tx_ovr_q & ~clr_ovr);
        rx_udr_d        = rx_udr_set  | (rx_udr_q & ~clr_udr);
        rx_err_cnt_d    = clr_err ? 8'd0 : rx_err_cnt_q;
        if (rx_err_rise && (rx_err_cnt_d != 8'hFF)) rx_err_cnt_d = rx_err_cnt_d + 8'd1;
    end

    // State, response and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            prdata_q        <= '0;
            pslverr_q       <= 1'b0;
            rx_error_q      <= 1'b0;
            rx_err_sticky_q <= 1'b0;
            tx_ovr_q        <= 1'b0;
            rx_udr_q        <= 1'b0;
            rx_err_cnt_q    <= '0;
        end else begin
            state_q         <= state_d;
            prdata_q        <= prdata_d;
            pslverr_q       <= pslverr_d;
            rx_error_q      <= rx_error;
            rx_err_sticky_q <= rx_err_sticky_d;
            tx_ovr_q        <= tx_ovr_d;
            rx_udr_q        <= rx_udr_d;
            rx_err_cnt_q    <= rx_err_cnt_d;
        end
    end

`ifdef APB_UART_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;

    assign ctrl_d     = (in_access && pwrite && sel_ctrl) ? pwdata[1:0] : ctrl_q;
    assign irq_d      = (ctrl_q[0] & ~rx_fifo_empty) |
                        (ctrl_q[1] & (rx_err_sticky_q | tx_ovr_q | rx_udr_q));
    assign ctrl_rdata = {30'd0, ctrl_q};
    assign irq        = irq_q;

    // Interrupt enables and the registered interrupt line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end
`else
    assign ctrl_rdata = '0;
`endif

endmodule
